// File: rtl/icache_line_filler_pkg.sv
// Shared I-cache miss-path types: filler FSM states, beat-count type and line-alignment helper.
package CacheSystemTypes;

    localparam int unsigned ICACHE_LINE_WIDTH     = 128;
    localparam int unsigned ICACHE_MEM_DATA_WIDTH = 32;
    localparam int unsigned ICACHE_LINE_BEATS     = ICACHE_LINE_WIDTH / ICACHE_MEM_DATA_WIDTH;

    typedef enum logic [1:0] {
        IC_FILLER_IDLE,
        IC_FILLER_REQ,
        IC_FILLER_RECV,
        IC_FILLER_FILL
    } IcFillerState;

    typedef logic [$clog2(ICACHE_LINE_BEATS)-1:0] IcBeatCount;

    // Zeroes the byte-offset bits; callers cast the result down to their address width.
    function automatic logic [63:0] ICacheLineAddr(input logic [63:0] addr,
                                                   input int unsigned offsetBits);
        logic [63:0] mask;
        mask = {64{1'b1}} << offsetBits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/icache_line_assembler.sv
// Collects memory response beats into one cache line; lastBeat flags the final beat of the line.
module icache_line_assembler #(
    parameter int unsigned LINE_WIDTH     = 128,
    parameter int unsigned MEM_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      beatValid,
    input  logic [MEM_DATA_WIDTH-1:0] beatData,
    output logic [LINE_WIDTH-1:0]     lineData,
    output logic                      lastBeat
);

    localparam int unsigned BEATS     = LINE_WIDTH / MEM_DATA_WIDTH;
    localparam int unsigned CNT_WIDTH = $clog2(BEATS);

    logic [CNT_WIDTH-1:0] beatCnt;

    assign lastBeat = beatValid && (beatCnt == CNT_WIDTH'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beatCnt  <= '0;
            lineData <= '0;
        end else if (clear) begin
            beatCnt <= '0;
        end else if (beatValid) begin
            lineData[beatCnt*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= beatData;
            // Explicit wrap keeps non-power-of-two beat counts correct.
            beatCnt <= lastBeat ? '0 : beatCnt + 1'b1;
        end
    end

endmodule

// File: rtl/icache_line_filler.sv
// I-cache miss handler: one line request per miss, beat assembly, single-cycle fill.
// Optional perf counters enabled by defining ICACHE_FILLER_PERF_COUNTER_EN.
module icache_line_filler
    import CacheSystemTypes::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned LINE_WIDTH     = 128,
    parameter int unsigned MEM_DATA_WIDTH = 32,
    parameter int unsigned WAY_PTR_WIDTH  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      icMiss,
    input  logic [ADDR_WIDTH-1:0]     icMissAddr,
    input  logic [WAY_PTR_WIDTH-1:0]  icVictimWayPtr,
    output logic                      icFill,
    output logic                      icFillerBusy,
    output logic [ADDR_WIDTH-1:0]     icFillAddr,
    output logic [WAY_PTR_WIDTH-1:0]  icFillWayPtr,
    output logic [LINE_WIDTH-1:0]     icFillData,
    output logic                      memReqValid,
    output logic [ADDR_WIDTH-1:0]     memReqAddr,
    input  logic                      memReqReady,
    input  logic                      memRspValid,
    input  logic [MEM_DATA_WIDTH-1:0] memRspData
`ifdef ICACHE_FILLER_PERF_COUNTER_EN
    ,
    output logic [31:0]               perfMissCount,
    output logic [31:0]               perfStallCycles,
    output logic [15:0]               perfSuppressCount
`endif
);

    localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8);

    IcFillerState             state;
    logic [ADDR_WIDTH-1:0]    capAddr;
    logic [WAY_PTR_WIDTH-1:0] capWay;
    logic                     suppress;
    logic [ADDR_WIDTH-1:0]    missLineAddr;
    logic                     suppressHit;
    logic                     missAccept;
    logic                     missSuppressed;
    logic                     beatValid;
    logic                     reqClear;
    logic                     lastBeat;

    assign missLineAddr   = ADDR_WIDTH'(ICacheLineAddr(64'(icMissAddr), OFFSET_BITS));
    // Stale-miss window: only the IDLE cycle right after a fill, same line only.
    assign suppressHit    = suppress && (missLineAddr == capAddr);
    assign missAccept     = (state == IC_FILLER_IDLE) && icMiss && !suppressHit;
    assign missSuppressed = (state == IC_FILLER_IDLE) && icMiss && suppressHit;
    assign beatValid      = (state == IC_FILLER_RECV) && memRspValid;
    assign reqClear       = (state == IC_FILLER_REQ) && memReqReady;

    icache_line_assembler #(
        .LINE_WIDTH     (LINE_WIDTH),
        .MEM_DATA_WIDTH (MEM_DATA_WIDTH)
    ) u_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (reqClear),
        .beatValid (beatValid),
        .beatData  (memRspData),
        .lineData  (icFillData),
        .lastBeat  (lastBeat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IC_FILLER_IDLE;
            capAddr      <= '0;
            capWay       <= '0;
            suppress     <= 1'b0;
            memReqValid  <= 1'b0;
            icFill       <= 1'b0;
            icFillerBusy <= 1'b0;
        end else begin
            icFill <= 1'b0;
            case (state)
                IC_FILLER_IDLE: begin
                    suppress <= 1'b0;
                    if (missAccept) begin
                        capAddr      <= missLineAddr;
                        capWay       <= icVictimWayPtr;
                        memReqValid  <= 1'b1;
                        icFillerBusy <= 1'b1;
                        state        <= IC_FILLER_REQ;
                    end
                end
                IC_FILLER_REQ: begin
                    if (memReqReady) begin
                        memReqValid <= 1'b0;
                        state       <= IC_FILLER_RECV;
                    end
                end
                IC_FILLER_RECV: begin
                    if (lastBeat) begin
                        icFill <= 1'b1;
                        state  <= IC_FILLER_FILL;
                    end
                end
                IC_FILLER_FILL: begin
                    suppress     <= 1'b1;
                    icFillerBusy <= 1'b0;
                    state        <= IC_FILLER_IDLE;
                end
                default: state <= IC_FILLER_IDLE;
            endcase
        end
    end

    assign memReqAddr   = capAddr;
    assign icFillAddr   = capAddr;
    assign icFillWayPtr = capWay;

`ifdef ICACHE_FILLER_PERF_COUNTER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perfMissCount     <= '0;
            perfStallCycles   <= '0;
            perfSuppressCount <= '0;
        end else begin
            if (missAccept && (perfMissCount != '1)) begin
                perfMissCount <= perfMissCount + 1'b1;
            end
            if (icFillerBusy && (perfStallCycles != '1)) begin
                perfStallCycles <= perfStallCycles + 1'b1;
            end
            if (missSuppressed && (perfSuppressCount != '1)) begin
                perfSuppressCount <= perfSuppressCount + 1'b1;
            end
        end
    end
`else
    logic unusedSuppressed;
    assign unusedSuppressed = missSuppressed;
`endif

`ifndef SYNTHESIS
    // Stray response beats are dropped; warn so the memory-side bug is visible.
    assert property (@(posedge clk) disable iff (rst) memRspValid |-> state == IC_FILLER_RECV)
        else $warning("icache_line_filler: memRspValid outside RECV ignored");
`endif

endmodule

// File: tb/tb_icache_line_filler.sv
// Directed self-checking bench for icache_line_filler (perf checks when ICACHE_FILLER_PERF_COUNTER_EN).
module tb_icache_line_filler;

    logic         clk = 1'b0;
    logic         rst;
    logic         icMiss;
    logic [31:0]  icMissAddr;
    logic [0:0]   icVictimWayPtr;
    logic         icFill;
    logic         icFillerBusy;
    logic [31:0]  icFillAddr;
    logic [0:0]   icFillWayPtr;
    logic [127:0] icFillData;
    logic         memReqValid;
    logic [31:0]  memReqAddr;
    logic         memReqReady;
    logic         memRspValid;
    logic [31:0]  memRspData;
`ifdef ICACHE_FILLER_PERF_COUNTER_EN
    logic [31:0]  perfMissCount;
    logic [31:0]  perfStallCycles;
    logic [15:0]  perfSuppressCount;
`endif

    int nAsserts = 0;
    int nFail    = 0;

    icache_line_filler dut (
        .clk            (clk),
        .rst            (rst),
        .icMiss         (icMiss),
        .icMissAddr     (icMissAddr),
        .icVictimWayPtr (icVictimWayPtr),
        .icFill         (icFill),
        .icFillerBusy   (icFillerBusy),
        .icFillAddr     (icFillAddr),
        .icFillWayPtr   (icFillWayPtr),
        .icFillData     (icFillData),
        .memReqValid    (memReqValid),
        .memReqAddr     (memReqAddr),
        .memReqReady    (memReqReady),
        .memRspValid    (memRspValid),
        .memRspData     (memRspData)
`ifdef ICACHE_FILLER_PERF_COUNTER_EN
        ,
        .perfMissCount     (perfMissCount),
        .perfStallCycles   (perfStallCycles),
        .perfSuppressCount (perfSuppressCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d);
        memRspValid = 1'b1;
        memRspData  = d;
        tick();
        memRspValid = 1'b0;
    endtask

    task automatic missReq(input logic [31:0] addr, input logic [0:0] way);
        icMiss         = 1'b1;
        icMissAddr     = addr;
        icVictimWayPtr = way;
        tick();
        icMiss = 1'b0;
    endtask

`ifdef ICACHE_FILLER_PERF_COUNTER_EN
    // Six busy cycles: REQ with immediate ready, four beats, FILL.
    task automatic serviceLine(input logic [31:0] addr);
        memReqReady = 1'b1;
        missReq(addr, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) beat(32'h50 + i);
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        icMiss = 1'b0; icMissAddr = '0; icVictimWayPtr = '0;
        memReqReady = 1'b0; memRspValid = 1'b0; memRspData = '0;
        tick(); tick();
        check("rstFill", icFill, 0);
        check("rstBusy", icFillerBusy, 0);
        check("rstReqValid", memReqValid, 0);
        check("rstData", icFillData, 0);
        rst = 1'b0;
        tick();

        // Basic miss, ready already high while idle
        memReqReady = 1'b1;
        missReq(32'h0000_1234, 1'b1);
        check("basicReqValid", memReqValid, 1);
        check("basicReqAddr", memReqAddr, 32'h0000_1230);
        check("basicBusyReq", icFillerBusy, 1);
        tick();
        check("basicReqDrop", memReqValid, 0);
        beat(32'hA0); beat(32'hA1); beat(32'hA2);
        check("basicNoEarlyFill", icFill, 0);
        beat(32'hA3);
        check("basicFill", icFill, 1);
        check("basicData", icFillData, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        check("basicWay", icFillWayPtr, 1);
        check("basicFillAddr", icFillAddr, 32'h0000_1230);
        check("basicBusyFill", icFillerBusy, 1);
        tick();
        check("basicFillPulse", icFill, 0);
        check("basicIdle", icFillerBusy, 0);

        // Backpressure: request held for five cycles
        memReqReady = 1'b0;
        missReq(32'h0000_5678, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bpReqValid", memReqValid, 1);
            check("bpReqAddr", memReqAddr, 32'h0000_5670);
            tick();
        end
        memReqReady = 1'b1;
        tick();
        check("bpReqDrop", memReqValid, 0);
        beat(32'hB0); beat(32'hB1); beat(32'hB2); beat(32'hB3);
        check("bpFill", icFill, 1);
        check("bpData", icFillData, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        check("bpWay", icFillWayPtr, 0);
        tick();

        // Spurious beat during REQ, gaps during RECV
        memReqReady = 1'b0;
        missReq(32'h0000_7000, 1'b1);
        memRspValid = 1'b1; memRspData = 32'hEE;
        tick();
        memRspValid = 1'b0; memReqReady = 1'b1;
        tick();
        beat(32'hC0);
        tick();
        check("gapNoFill", icFill, 0);
        beat(32'hC1);
        tick(); tick();
        beat(32'hC2);
        check("gapNoFill3", icFill, 0);
        beat(32'hC3);
        check("gapFill", icFill, 1);
        check("gapData", icFillData, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        tick();

        // Miss while busy, then stale-miss suppression
        missReq(32'h0000_1234, 1'b0);
        tick();
        beat(32'hD0);
        icMiss = 1'b1; icMissAddr = 32'h0000_2000;
        beat(32'hD1);
        icMiss = 1'b0;
        beat(32'hD2); beat(32'hD3);
        check("busyFill", icFill, 1);
        check("busyFillAddr", icFillAddr, 32'h0000_1230);
        check("busyData", icFillData, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        icMiss = 1'b1; icMissAddr = 32'h0000_9990;
        tick();
        check("fillMissIgnored", memReqValid, 0);
        check("fillMissIdle", icFillerBusy, 0);
        icMissAddr = 32'h0000_1238;
        tick();
        check("staleSuppressed", memReqValid, 0);
        check("staleNotBusy", icFillerBusy, 0);
        tick();
        check("staleRetryValid", memReqValid, 1);
        check("staleRetryAddr", memReqAddr, 32'h0000_1230);
        icMiss = 1'b0;
        tick();
        beat(32'hE0); beat(32'hE1); beat(32'hE2); beat(32'hE3);
        check("retryData", icFillData, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
        icMiss = 1'b1; icMissAddr = 32'h0000_1240;
        tick();
        tick();
        check("diffLineValid", memReqValid, 1);
        check("diffLineAddr", memReqAddr, 32'h0000_1240);
        icMiss = 1'b0;
        tick();
        beat(32'h1); beat(32'h2); beat(32'h3); beat(32'h4);
        check("diffLineFill", icFill, 1);
        tick();

        // Reset in the middle of RECV
        missReq(32'h0000_4444, 1'b1);
        tick();
        beat(32'hF0); beat(32'hF1);
        #1 rst = 1'b1;
        #1;
        check("midRstBusy", icFillerBusy, 0);
        check("midRstReq", memReqValid, 0);
        check("midRstData", icFillData, 0);
        check("midRstAddr", icFillAddr, 0);
        check("midRstWay", icFillWayPtr, 0);
        rst = 1'b0;
        tick();
        missReq(32'h0000_3000, 1'b0);
        check("postRstReqAddr", memReqAddr, 32'h0000_3000);
        tick();
        beat(32'h11); beat(32'h12); beat(32'h13); beat(32'h14);
        check("postRstFill", icFill, 1);
        check("postRstData", icFillData, {32'h14, 32'h13, 32'h12, 32'h11});
        check("postRstFillAddr", icFillAddr, 32'h0000_3000);
        tick();

`ifdef ICACHE_FILLER_PERF_COUNTER_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("perfRstMiss", perfMissCount, 0);
        tick();
        serviceLine(32'h0000_0100);
        icMiss = 1'b1; icMissAddr = 32'h0000_0104;
        tick();
        icMiss = 1'b0;
        serviceLine(32'h0000_0200);
        serviceLine(32'h0000_0300);
        check("perfMiss", perfMissCount, 3);
        check("perfSuppress", perfSuppressCount, 1);
        check("perfStall", perfStallCycles, 18);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/icache_line_filler.md
Name: icache_line_filler

Overview:
- Miss handler for the instruction cache; consumes the I-cache miss outputs and produces its fill inputs.
- On a miss it captures the line-aligned miss address and victim way, and issues one line request to the memory side.
- It assembles the returned beats into a full line, then drives a single-cycle fill into the I-cache.
- It holds icFillerBusy whenever a miss is in flight.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_WIDTH, 128, I-cache line width in bits.
- MEM_DATA_WIDTH, 32, memory response beat width; BEATS = LINE_WIDTH/MEM_DATA_WIDTH, must be an integer ≥ 2.
- WAY_PTR_WIDTH, 1, victim way pointer width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- icMiss  in  1  I-cache miss this cycle.
- icMissAddr  in  ADDR_WIDTH  miss address.
- icVictimWayPtr  in  WAY_PTR_WIDTH  way to replace.
- icFill  out  1  fill strobe, one cycle.
- icFillerBusy  out  1  miss in flight.
- icFillAddr  out  ADDR_WIDTH  line-aligned fill address.
- icFillWayPtr  out  WAY_PTR_WIDTH  way being filled.
- icFillData  out  LINE_WIDTH  assembled line.
- memReqValid  out  1  line read request.
- memReqAddr  out  ADDR_WIDTH  line-aligned request address.
- memReqReady  in  1  memory accepts request.
- memRspValid  in  1  response beat valid.
- memRspData  in  MEM_DATA_WIDTH  response beat.

Behaviour:
- Reset (async, rst=1) state and outputs:
  - State is IDLE.
  - All outputs are 0.
  - Beat counter, line buffer, captured address/way and the suppress flag are all cleared.
  - Reset mid-operation abandons the miss; any in-flight memory beats are lost, and the memory side shares rst.
- FSM states: IDLE, REQ, RECV, FILL.
- IDLE:
  - If icMiss=1 and not suppressed, capture addr = icMissAddr with the low log2(LINE_WIDTH/8) bits zeroed, capture way = icVictimWayPtr, and go to REQ.
- REQ:
  - memReqValid=1, memReqAddr = captured addr.
  - Request is held stable until memReqReady=1; on that cycle go to RECV with beat counter 0.
- RECV:
  - Each memRspValid=1 cycle writes memRspData to line bits [cnt*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] and increments cnt.
  - On the beat with cnt = BEATS-1, go to FILL.
  - Gaps between beats are allowed.
- FILL (exactly one cycle), then IDLE:
  - icFill=1; icFillAddr, icFillWayPtr and icFillData are taken from the captured registers.
  - The suppress flag is set with the filled line address.
- icFillerBusy = 1 in REQ, RECV and FILL; 0 in IDLE.
- Latency:
  - Miss seen in cycle t → memReqValid at t+1.
  - With memReqReady=1 at t+1 and back-to-back beats from t+2, icFill is at t+2+BEATS.
- Boundary conditions:
  - icMiss while busy (including during FILL): ignored; the I-cache re-asserts the miss later.
  - Stale-miss suppression: in the single IDLE cycle immediately after FILL, an icMiss whose line address equals the just-filled line is ignored. The suppress flag clears after that cycle regardless. A different line address is accepted normally.
  - memRspValid outside RECV: ignored, and flagged by a simulation-only assertion.
  - memReqReady outside REQ: ignored.
  - Address wrap: none required; the address is only masked, never incremented.

Optional Feature:
- Macro: ICACHE_FILLER_PERF_COUNTER_EN.
- When defined, adds three outputs:
  - perfMissCount (32 bits): increments on each accepted miss.
  - perfStallCycles (32 bits): increments each cycle icFillerBusy=1.
  - perfSuppressCount (16 bits): increments on each suppressed stale miss.
  - All three reset to 0 and saturate at all-ones.
- When undefined, these ports and their logic are absent; core behaviour is identical either way.

Decomposition:
- CacheSystemTypes package:
  - ICACHE_LINE_BEATS constant.
  - IcFillerState enum {IC_FILLER_IDLE, IC_FILLER_REQ, IC_FILLER_RECV, IC_FILLER_FILL}.
  - Beat-count type of width $clog2(BEATS).
  - ICacheLineAddr helper (line-alignment mask).
- One natural sub-module: icache_line_assembler.
  - Contents: beat counter plus line shift/index buffer.
  - Ports: clear, beatValid, beatData → lineData, lastBeat.

Test Plan:
- Basic miss: icMiss=1, icMissAddr=0x0000_1234, way=1 at t; memReqReady=1 at t+1; beats 0xA0,0xA1,0xA2,0xA3 → memReqAddr=0x0000_1230 at t+1, icFill at t+6 with icFillData=0x000000A3_000000A2_000000A1_000000A0, icFillWayPtr=1, busy high t+1..t+6.
- Backpressure: memReqReady low for 5 cycles → memReqValid and memReqAddr held stable for all 5, no beat accepted until after the handshake.
- Gapped beats plus spurious traffic: a memRspValid pulse during REQ and idle cycles between beats → the REQ pulse is ignored, the line is assembled correctly, icFill is on the cycle after the 4th valid beat.
- Miss during busy and stale miss:
  - icMiss=0x2000 during RECV → no effect.
  - icMiss=0x1238 the cycle after filling 0x1230 → suppressed.
  - icMiss=0x1240 in that same cycle → accepted.
- Reset mid-RECV: assert rst after 2 beats → all outputs 0 immediately; after release, a new miss to 0x3000 completes with fresh data and no leftover beats.
- ICACHE_FILLER_PERF_COUNTER_EN build: 3 misses with 1 suppressed and 6-cycle services → perfMissCount=3, perfSuppressCount=1, perfStallCycles=18.
